// File: rtl/abacus_pkg.sv
// rtl/abacus_pkg.sv - shared constants, FSM state type and sizing helper for the BCD converter
package abacus_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int DEF_BIN_W   = 16;
    localparam int DEF_DIGITS  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } conv_state_t;

    // Decimal digits needed for 2^bin_w-1: floor(bin_w*log10(2))+1, since 2^n is never a power of ten
    function automatic int digits_needed(input int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble digit correction: add 3 (mod 16) when the digit is 5 or more
module bcd_add3_digit
    import abacus_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_DIGIT_W'(5)) ? digit_in + BCD_DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential binary-to-BCD converter (macro BCD_AUTO_CONV_EN enables auto conversion on input change)
module bcd_seq_converter
    import abacus_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                          clk,
    input  logic                          clr_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcdout
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (DIGITS < digits_needed(BIN_W)) begin : g_digits_check
        $error("bcd_seq_converter: DIGITS too small to hold 2^BIN_W-1");
    end

    conv_state_t      state;
    conv_state_t      state_next;
    logic [BIN_W-1:0] bin_reg;
    logic [BCD_W-1:0] work;
    logic [BCD_W-1:0] work_adj;
    logic [CNT_W-1:0] cnt;
    logic             trigger;
    logic             carry_unused;

    // Top bit shifted out of the work register; always zero for inputs that fit DIGITS
    assign carry_unused = work_adj[BCD_W-1];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_in  (work[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (work_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_AUTO_CONV_EN
    logic [BIN_W-1:0] last_val;

    // Remember the most recently captured operand so a change in bin_in can self-start
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_val <= '0;
        end else if (state == IDLE && trigger) begin
            last_val <= bin_in;
        end
    end

    assign trigger = start | (bin_in != last_val);
`else
    assign trigger = start;
`endif

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept a request only in IDLE, run BIN_W shifts, then one FINISH cycle
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operand, shift-and-correct, publish result with a one-cycle done
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bin_reg <= '0;
            work    <= '0;
            cnt     <= '0;
            bcdout  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        bin_reg <= bin_in;
                        work    <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    work    <= {work_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
                    bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    bcdout <= work;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - directed scoreboard bench for bcd_seq_converter
module tb_bcd_seq_converter;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

    logic                clk    = 1'b0;
    logic                clr_n  = 1'b0;
    logic                start  = 1'b0;
    logic [BIN_W-1:0]    bin_in = '0;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcdout;

    int n_cmp      = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int done_total = 0;
    logic [4*DIGITS-1:0] exp_q[$];

    bcd_seq_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .bcdout (bcdout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_total++;
            check("done_excludes_busy", {31'd0, busy}, 32'd0);
            check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("bcdout", 32'(bcdout), 32'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_conv(input int v, output int k);
        step();
        bin_in = BIN_W'(v);
        start  = 1'b1;
        exp_q.push_back(to_bcd(v));
        step();
        start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input int budget, output int at);
        bit found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (done === 1'b1) begin
                found = 1'b1;
                at = cyc;
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d, d1, d2, base;
        int vals[3] = '{65535, 255, 100};

        step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_bcdout", 32'(bcdout), 32'd0);
        step();

`ifdef BCD_AUTO_CONV_EN
        clr_n = 1'b1;
        idle_steps(20);
        check("auto_idle_no_done", done_total, 0);
        bin_in = BIN_W'(37);
        exp_q.push_back(to_bcd(37));
        wait_done(40, d);
        idle_steps(40);
        check("auto_single_done", done_total, 1);
        check("auto_hold_bcdout", 32'(bcdout), 32'h00037);
`else
        // First start on the very first edge after reset release
        clr_n  = 1'b1;
        bin_in = '0;
        start  = 1'b1;
        exp_q.push_back(to_bcd(0));
        step();
        start = 1'b0;
        k = cyc;
        check("first_start_busy", {31'd0, busy}, 32'd1);
        wait_done(40, d);
        check("latency_zero", d - k, 17);

        for (int i = 0; i < 3; i++) begin
            start_conv(vals[i], k);
            wait_done(40, d);
            check("latency", d - k, 17);
        end
        step();
        check("hold_after_done", 32'(bcdout), 32'h00100);

        // Start during a conversion is dropped, bin_in changes ignored
        base = done_total;
        start_conv(1234, k);
        while (cyc < k + 4) step();
        bin_in = BIN_W'(9999);
        start  = 1'b1;
        step();
        start = 1'b0;
        wait_done(40, d);
        check("ignored_latency", d - k, 17);
        idle_steps(40);
        check("ignored_one_done", done_total - base, 1);
        check("ignored_hold", 32'(bcdout), 32'h01234);

        // Back-to-back: start in the done cycle
        start_conv(42, k);
        wait_done(40, d1);
        bin_in = BIN_W'(7);
        start  = 1'b1;
        exp_q.push_back(to_bcd(7));
        step();
        start = 1'b0;
        wait_done(40, d2);
        check("b2b_spacing", d2 - d1, 18);

        // Reset mid-conversion
        start_conv(500, k);
        while (cyc < k + 7) step();
        clr_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_bcdout", 32'(bcdout), 32'd0);
        void'(exp_q.pop_back());
        base = done_total;
        idle_steps(3);
        clr_n = 1'b1;
        idle_steps(30);
        check("midrst_no_done", done_total - base, 0);
        start_conv(500, k);
        wait_done(40, d);
        check("after_rst_latency", d - k, 17);
        idle_steps(5);
        check("after_rst_hold", 32'(bcdout), 32'h00500);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
